// File: rtl/rtt_stamper.sv
// Stamps the first body word of RTT probe frames with a free-running cycle counter; all else passes through.
// Latency 1 cycle (fallthrough FIFO); out_rdy=0 holds FIFO, parser and match; in_rdy drops at 3 of 4 entries.

module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] NF_LEVEL = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0] FULL_LEVEL = (MAX_DEPTH_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign empty       = (depth == '0);
  assign nearly_full = (depth >= NF_LEVEL);
  assign do_wr       = wr_en && (depth != FULL_LEVEL);
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + (MAX_DEPTH_BITS+1)'(1);
        2'b01:   depth <= depth - (MAX_DEPTH_BITS+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module rtt_stamper #(
  parameter int          DATA_WIDTH      = 64,
  parameter int          CTRL_WIDTH      = DATA_WIDTH/8,
  parameter logic [15:0] PROBE_ETHERTYPE = 16'h0801
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  stamp_en,
  output logic [31:0]           stamp_cnt,
  output logic [63:0]           timestamp
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_W1   = 3'd2;
  localparam logic [2:0] S_W2   = 3'd3;
  localparam logic [2:0] S_BODY = 3'd4;

  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0]            head_data;
  logic [CTRL_WIDTH-1:0]            head_ctrl;
  logic                             fifo_empty;
  logic                             fifo_nearly_full;
  logic                             xfer;
  logic                             ctrl_zero;
  logic                             stamp_now;
  logic                             match;
  logic [2:0]                       state;
  logic [2:0]                       nxt_state;

  fallthrough_small_fifo #(
    .WIDTH          (DATA_WIDTH + CTRL_WIDTH),
    .MAX_DEPTH_BITS (2)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (xfer),
    .dout        (fifo_dout),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign in_rdy    = !fifo_nearly_full;
  assign head_data = fifo_dout[DATA_WIDTH-1:0];
  assign head_ctrl = fifo_dout[DATA_WIDTH +: CTRL_WIDTH];
  assign ctrl_zero = (head_ctrl == '0);

  // Outputs are forced quiet while reset is held, even if stale words sit at the FIFO head.
  assign xfer      = reset && !fifo_empty && out_rdy;
  assign stamp_now = xfer && (state == S_W2) && match && stamp_en && ctrl_zero;
  assign out_wr    = xfer;
  assign out_ctrl  = reset ? head_ctrl : '0;
  assign out_data  = !reset ? '0 : (stamp_now ? DATA_WIDTH'(timestamp) : head_data);

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:       nxt_state = ctrl_zero ? S_IDLE : S_HDR;
      S_HDR:        nxt_state = ctrl_zero ? S_W1   : S_HDR;
      S_W1:         nxt_state = ctrl_zero ? S_W2   : S_IDLE;
      S_W2, S_BODY: nxt_state = ctrl_zero ? S_BODY : S_IDLE;
      default:      nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      match     <= 1'b0;
      stamp_cnt <= '0;
      timestamp <= '0;
    end else begin
      timestamp <= timestamp + 64'd1;
      if (xfer) state <= nxt_state;
      // Ethertype sits in bits [31:16] of the second payload word.
      if (xfer && (state == S_W1) && ctrl_zero) match <= (head_data[31:16] == PROBE_ETHERTYPE);
      if (stamp_now) stamp_cnt <= stamp_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_rtt_stamper.sv
// Directed bench for rtt_stamper: probe/non-probe stamping, short frames, backpressure, mid-packet reset, stamp_en.
module tb_rtt_stamper;
  localparam logic [63:0] HDR_D    = 64'h0005_0008_0000_0040;
  localparam logic [63:0] W0_D     = 64'h0011_2233_4455_0011;
  localparam logic [63:0] W1_PROBE = 64'h2233_4455_0801_4444;
  localparam logic [63:0] W1_OTHER = 64'h2233_4455_0800_4444;
  localparam logic [63:0] BODY_D   = 64'h0011_2233_4455_6677;
  localparam logic [63:0] EOP_D    = 64'h8899_aabb_ccdd_eeff;

  typedef struct packed { logic [63:0] d; logic [7:0] c; logic st; } exp_t;
  typedef struct packed { logic [63:0] d; logic [7:0] c; logic [63:0] ts; } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        stamp_en = 1'b0;
  logic [31:0] stamp_cnt;
  logic [63:0] timestamp;

  int          total = 0;
  int          bad = 0;
  int          bp_total = 0;
  int          bp_bad = 0;
  bit          bp_chk = 1'b0;
  bit          saw_full = 1'b0;
  int          occ = 0;
  logic [63:0] ts_m = '0;
  logic [63:0] exp_d;
  exp_t        exp_q[$];
  obs_t        mon_q[$];

  rtt_stamper dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_wr     (in_wr),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wr    (out_wr),
    .out_rdy   (out_rdy),
    .stamp_en  (stamp_en),
    .stamp_cnt (stamp_cnt),
    .timestamp (timestamp)
  );

  always #5 clk = ~clk;

  // Reference cycle counter and occupancy, derived only from the clock, reset and handshake strobes.
  always @(posedge clk) begin
    if (!reset) begin
      ts_m <= '0;
      occ  <= 0;
    end else begin
      ts_m <= ts_m + 64'd1;
      occ  <= occ + (in_wr ? 1 : 0) - (out_wr ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (out_wr === 1'b1) mon_q.push_back({out_data, out_ctrl, ts_m});
    if (bp_chk) begin
      bp_total++;
      if (in_rdy !== (occ < 3)) begin
        bp_bad++;
        $display("FAIL bp_in_rdy occ=%0d got %b exp %b", occ, in_rdy, (occ < 3));
      end
      if (in_rdy === 1'b0) saw_full = 1'b1;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] c, input logic st);
    int k = 0;
    while (in_rdy !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    exp_q.push_back({d, c, st});
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] w1, input logic st);
    push_word(HDR_D, 8'hff, 1'b0);
    push_word(W0_D, 8'h00, 1'b0);
    push_word(w1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) push_word(BODY_D, 8'h00, (i == 0) ? st : 1'b0);
    push_word(EOP_D, 8'hff, 1'b0);
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 500 && mon_q.size() < n; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_wr !== 1'b0 || out_data !== 64'd0 || out_ctrl !== 8'd0) begin
      bad++;
      $display("FAIL rst_outputs got wr=%b d=%h c=%h exp 0/0/0", out_wr, out_data, out_ctrl);
    end
    @(posedge clk); #1 reset = 1'b1;
    total++;
    if (in_rdy !== 1'b1 || stamp_cnt !== 32'd0 || timestamp !== 64'd0) begin
      bad++;
      $display("FAIL rst_state got rdy=%b cnt=%0d ts=%0d exp 1/0/0", in_rdy, stamp_cnt, timestamp);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (timestamp !== 64'd5) begin
      bad++;
      $display("FAIL ts_count got %0d exp 5", timestamp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_probe();
    do_reset();
    stamp_en = 1'b1;
    out_rdy  = 1'b1;
    send_pkt(W1_PROBE, 1'b1);
    wait_out(9);
    total++;
    if (mon_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL probe_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      total++;
      exp_d = exp_q[i].st ? mon_q[i].ts : exp_q[i].d;
      if (mon_q[i].d !== exp_d || mon_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL probe_w%0d got %h/%h exp %h/%h", i, mon_q[i].d, mon_q[i].c, exp_d, exp_q[i].c);
      end
    end
    total++;
    if (stamp_cnt !== 32'd1) begin
      bad++;
      $display("FAIL probe_cnt got %0d exp 1", stamp_cnt);
    end
    total++;
    if (timestamp !== ts_m) begin
      bad++;
      $display("FAIL probe_ts got %0d exp %0d", timestamp, ts_m);
    end
  endtask

  task automatic test_nonprobe();
    do_reset();
    stamp_en = 1'b1;
    send_pkt(W1_OTHER, 1'b0);
    wait_out(9);
    total++;
    if (mon_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL nonprobe_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i].d !== exp_q[i].d || mon_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL nonprobe_w%0d got %h/%h exp %h/%h", i, mon_q[i].d, mon_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    total++;
    if (stamp_cnt !== 32'd0) begin
      bad++;
      $display("FAIL nonprobe_cnt got %0d exp 0", stamp_cnt);
    end
  endtask

  task automatic test_short();
    do_reset();
    stamp_en = 1'b1;
    push_word(HDR_D, 8'hff, 1'b0);
    push_word(W0_D, 8'h00, 1'b0);
    push_word(EOP_D, 8'hff, 1'b0);
    push_word(HDR_D, 8'hff, 1'b0);
    push_word(W0_D, 8'h00, 1'b0);
    push_word(W1_PROBE, 8'h00, 1'b0);
    push_word(EOP_D, 8'hff, 1'b0);
    wait_out(7);
    total++;
    if (stamp_cnt !== 32'd0) begin
      bad++;
      $display("FAIL short_cnt0 got %0d exp 0", stamp_cnt);
    end
    send_pkt(W1_PROBE, 1'b1);
    wait_out(16);
    total++;
    if (mon_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL short_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      total++;
      exp_d = exp_q[i].st ? mon_q[i].ts : exp_q[i].d;
      if (mon_q[i].d !== exp_d || mon_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL short_w%0d got %h/%h exp %h/%h", i, mon_q[i].d, mon_q[i].c, exp_d, exp_q[i].c);
      end
    end
    total++;
    if (stamp_cnt !== 32'd1) begin
      bad++;
      $display("FAIL short_cnt1 got %0d exp 1", stamp_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    stamp_en = 1'b1;
    bp_total = 0;
    bp_bad   = 0;
    saw_full = 1'b0;
    bp_chk   = 1'b1;
    fork
      send_pkt(W1_PROBE, 1'b1);
      begin
        for (int i = 0; i < 300 && mon_q.size() < 9; i++) begin
          out_rdy = ~out_rdy;
          @(posedge clk); #1;
        end
      end
    join
    bp_chk  = 1'b0;
    out_rdy = 1'b1;
    wait_out(9);
    total += bp_total;
    bad   += bp_bad;
    total++;
    if (!saw_full) begin
      bad++;
      $display("FAIL bp_full got in_rdy never low exp low at occupancy 3");
    end
    total++;
    if (mon_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      total++;
      exp_d = exp_q[i].st ? mon_q[i].ts : exp_q[i].d;
      if (mon_q[i].d !== exp_d || mon_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL bp_w%0d got %h/%h exp %h/%h", i, mon_q[i].d, mon_q[i].c, exp_d, exp_q[i].c);
      end
    end
    total++;
    if (stamp_cnt !== 32'd1) begin
      bad++;
      $display("FAIL bp_cnt got %0d exp 1", stamp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    stamp_en = 1'b1;
    out_rdy  = 1'b0;
    push_word(HDR_D, 8'hff, 1'b0);
    push_word(W0_D, 8'h00, 1'b0);
    push_word(W1_PROBE, 8'h00, 1'b0);
    reset   = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (out_wr !== 1'b0 || out_data !== 64'd0) begin
      bad++;
      $display("FAIL midrst_quiet got wr=%b d=%h exp 0/0", out_wr, out_data);
    end
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    total++;
    if (stamp_cnt !== 32'd0 || timestamp !== 64'd0 || mon_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_state got cnt=%0d ts=%0d out=%0d exp 0/0/0", stamp_cnt, timestamp, mon_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 5; i++) push_word(BODY_D, 8'h00, 1'b0);
    push_word(EOP_D, 8'hff, 1'b0);
    send_pkt(W1_PROBE, 1'b1);
    wait_out(15);
    total++;
    if (mon_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midrst_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      total++;
      exp_d = exp_q[i].st ? mon_q[i].ts : exp_q[i].d;
      if (mon_q[i].d !== exp_d || mon_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL midrst_w%0d got %h/%h exp %h/%h", i, mon_q[i].d, mon_q[i].c, exp_d, exp_q[i].c);
      end
    end
    total++;
    if (stamp_cnt !== 32'd1) begin
      bad++;
      $display("FAIL midrst_cnt got %0d exp 1", stamp_cnt);
    end
  endtask

  task automatic test_stamp_en();
    logic [63:0] prev;
    do_reset();
    stamp_en = 1'b0;
    for (int p = 0; p < 10; p++) send_pkt(W1_PROBE, 1'b0);
    wait_out(90);
    total++;
    if (mon_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL en0_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i].d !== exp_q[i].d || mon_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL en0_w%0d got %h/%h exp %h/%h", i, mon_q[i].d, mon_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    total++;
    if (stamp_cnt !== 32'd0) begin
      bad++;
      $display("FAIL en0_cnt got %0d exp 0", stamp_cnt);
    end
    mon_q.delete();
    exp_q.delete();
    stamp_en = 1'b1;
    for (int p = 0; p < 10; p++) send_pkt(W1_PROBE, 1'b1);
    wait_out(90);
    total++;
    if (mon_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL en1_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    prev = '0;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      total++;
      exp_d = exp_q[i].st ? mon_q[i].ts : exp_q[i].d;
      if (mon_q[i].d !== exp_d || mon_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL en1_w%0d got %h/%h exp %h/%h", i, mon_q[i].d, mon_q[i].c, exp_d, exp_q[i].c);
      end
      if (exp_q[i].st) begin
        total++;
        if (mon_q[i].d <= prev) begin
          bad++;
          $display("FAIL en1_mono_w%0d got %0d exp > %0d", i, mon_q[i].d, prev);
        end
        prev = mon_q[i].d;
      end
    end
    total++;
    if (stamp_cnt !== 32'd10) begin
      bad++;
      $display("FAIL en1_cnt got %0d exp 10", stamp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_probe();
    test_nonprobe();
    test_short();
    test_backpressure();
    test_mid_reset();
    test_stamp_en();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no completion exp finish before 300000");
    $fatal(1, "watchdog expired");
  end
endmodule
